// File: rtl/gbb_match_ctrl_if.sv
// Purpose: bundles the match controller's control, choice and score signals.
// Latency: none, wiring only.
// Backpressure: none; players present choices with a per-cycle valid.
interface gbb_match_ctrl_if;
    logic       start;
    logic       abort;
    logic [1:0] p1_sel;
    logic [1:0] p2_sel;
    logic       p1_valid;
    logic       p2_valid;
    logic [1:0] cmp_p1;
    logic [1:0] cmp_p2;
    logic [1:0] cmp_result;
    logic       clr_gbb;
    logic       window_open;
    logic [2:0] state;
    logic [2:0] p1_score;
    logic [2:0] p2_score;
    logic [3:0] round_cnt;
    logic       led_p1;
    logic       led_p2;
    logic       win_p1;
    logic       win_p2;

    // Environment side: players, control and the external comparator.
    modport master (
        output start, abort, p1_sel, p2_sel, p1_valid, p2_valid, cmp_result,
        input  cmp_p1, cmp_p2, clr_gbb, window_open, state,
               p1_score, p2_score, round_cnt, led_p1, led_p2, win_p1, win_p2
    );

    // Controller side.
    modport slave (
        input  start, abort, p1_sel, p2_sel, p1_valid, p2_valid, cmp_result,
        output cmp_p1, cmp_p2, clr_gbb, window_open, state,
               p1_score, p2_score, round_cnt, led_p1, led_p2, win_p1, win_p2
    );
endinterface

// File: rtl/gbb_match_ctrl.sv
// Purpose: rock/scissor/paper match controller: collect window, judge, score, match end.
// Latency: both choices in a cycle -> JUDGE next edge -> SCORE one edge later; all outputs registered.
// Backpressure: none; the first non-zero valid per player per round is latched, later ones dropped.
module gbb_match_ctrl #(
    parameter int WIN_TARGET = 3,
    parameter int WINDOW_CYC = 8
) (
    input  logic             ck,
    input  logic             reset_n,
    gbb_match_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        COLLECT = 3'b001,
        JUDGE   = 3'b010,
        SCORE   = 3'b011,
        DONE    = 3'b100
    } state_e;

    localparam logic [9:0] WIN_LOAD = 10'(WINDOW_CYC - 1);
    localparam logic [2:0] TARGET   = 3'(WIN_TARGET);

    state_e     st_q;
    logic [1:0] lat1_q, lat2_q;
    logic [9:0] cnt_q;
    logic [2:0] s1_q, s2_q;
    logic [3:0] rnd_q;
    logic       clr_q, led1_q, led2_q, win1_q, win2_q;

    logic [1:0] nxt1, nxt2;
    logic       go_score, award_p2;

    // Choice seen this cycle: an occupied latch is sticky; a sel of 00 leaves it empty.
    always_comb begin
        nxt1 = lat1_q;
        nxt2 = lat2_q;
        if (lat1_q == 2'b00 && bus.p1_valid) nxt1 = bus.p1_sel;
        if (lat2_q == 2'b00 && bus.p2_valid) nxt2 = bus.p2_sel;
    end

    // Round decided this cycle: forfeit on window expiry, or a decisive comparator answer.
    always_comb begin
        go_score = 1'b0;
        award_p2 = 1'b0;
        if (st_q == COLLECT) begin
            go_score = (cnt_q == 10'd0) && ((nxt1 != 2'b00) != (nxt2 != 2'b00));
            award_p2 = (nxt2 != 2'b00);
        end else if (st_q == JUDGE) begin
            go_score = bus.cmp_result[1];
            award_p2 = bus.cmp_result[0];
        end
    end

    // Match FSM with registered pulses, scores and latches; abort overrides everything.
    always_ff @(posedge ck or negedge reset_n) begin
        if (!reset_n) begin
            st_q   <= IDLE;
            lat1_q <= 2'b00;
            lat2_q <= 2'b00;
            cnt_q  <= 10'd0;
            s1_q   <= 3'd0;
            s2_q   <= 3'd0;
            rnd_q  <= 4'd0;
            clr_q  <= 1'b0;
            led1_q <= 1'b0;
            led2_q <= 1'b0;
            win1_q <= 1'b0;
            win2_q <= 1'b0;
        end else begin
            clr_q  <= 1'b0;
            led1_q <= 1'b0;
            led2_q <= 1'b0;
            if (bus.abort) begin
                st_q   <= IDLE;
                lat1_q <= 2'b00;
                lat2_q <= 2'b00;
                cnt_q  <= 10'd0;
                s1_q   <= 3'd0;
                s2_q   <= 3'd0;
                rnd_q  <= 4'd0;
                clr_q  <= 1'b1;
                win1_q <= 1'b0;
                win2_q <= 1'b0;
            end else begin
                case (st_q)
                    IDLE, DONE: begin
                        if (bus.start) begin
                            st_q   <= COLLECT;
                            lat1_q <= 2'b00;
                            lat2_q <= 2'b00;
                            cnt_q  <= WIN_LOAD;
                            s1_q   <= 3'd0;
                            s2_q   <= 3'd0;
                            rnd_q  <= 4'd0;
                            clr_q  <= 1'b1;
                            win1_q <= 1'b0;
                            win2_q <= 1'b0;
                        end
                    end
                    COLLECT: begin
                        lat1_q <= nxt1;
                        lat2_q <= nxt2;
                        if (nxt1 != 2'b00 && nxt2 != 2'b00) begin
                            st_q <= JUDGE;
                        end else if (cnt_q == 10'd0) begin
                            // Empty window: void round, open a fresh one.
                            if (!go_score) begin
                                cnt_q <= WIN_LOAD;
                                clr_q <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q - 10'd1;
                        end
                    end
                    JUDGE: begin
                        if (!go_score) begin
                            st_q   <= COLLECT;
                            lat1_q <= 2'b00;
                            lat2_q <= 2'b00;
                            cnt_q  <= WIN_LOAD;
                            clr_q  <= 1'b1;
                        end
                    end
                    SCORE: begin
                        if (s1_q == TARGET || s2_q == TARGET) begin
                            st_q   <= DONE;
                            win1_q <= (s1_q == TARGET);
                            win2_q <= (s2_q == TARGET);
                        end else begin
                            st_q   <= COLLECT;
                            lat1_q <= 2'b00;
                            lat2_q <= 2'b00;
                            cnt_q  <= WIN_LOAD;
                            clr_q  <= 1'b1;
                        end
                    end
                    default: st_q <= IDLE;
                endcase

                // Award lands on entry to SCORE so score and LED are visible during SCORE.
                if (go_score) begin
                    st_q  <= SCORE;
                    rnd_q <= (rnd_q == 4'hF) ? rnd_q : rnd_q + 4'd1;
                    if (award_p2) begin
                        s2_q   <= s2_q + 3'd1;
                        led2_q <= 1'b1;
                    end else begin
                        s1_q   <= s1_q + 3'd1;
                        led1_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.cmp_p1      = lat1_q;
    assign bus.cmp_p2      = lat2_q;
    assign bus.clr_gbb     = clr_q;
    assign bus.window_open = (st_q == COLLECT);
    assign bus.state       = st_q;
    assign bus.p1_score    = s1_q;
    assign bus.p2_score    = s2_q;
    assign bus.round_cnt   = rnd_q;
    assign bus.led_p1      = led1_q;
    assign bus.led_p2      = led2_q;
    assign bus.win_p1      = win1_q;
    assign bus.win_p2      = win2_q;

endmodule
